i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 148 ++++++++++++++
 tb/tb_i2s_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers mono samples in a small FIFO and sends each one
// duplicated to both channels, MSB first, with the standard one-bit delay.
module i2s_tx #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
);

    localparam int         PW       = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [2:0] DEPTH    = 3'(FIFO_DEPTH);

    logic [7:0]    div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic          underrun_q, underrun_d;
    logic          ready_q, ready_d;
    logic [15:0]   s_q, s_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];

    logic          div_wrap;
    logic          fall;
    logic [4:0]    new_bit;
    logic          frame_start;
    logic          push;
    logic          pop;
    logic [31:0]   frame;
    logic [4:0]    bit_idx;

    // Handshake: a sample transfers on every rising edge where sample_valid
    // and sample_ready are both high; sample_ready never depends on sample_valid.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        bclk_d     = bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        s_d        = s_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;

        div_wrap    = (div_cnt_q == DIV_LAST);
        fall        = div_wrap && bclk_q;
        new_bit     = bit_cnt_q + 5'd1;
        frame_start = fall && (new_bit == 5'd0);
        push        = sample_valid && ready_q;
        // Pop decision uses the registered occupancy, so a same-cycle push
        // into an empty FIFO is never forwarded to the frame.
        pop         = frame_start && (count_q != 3'd0);
        frame       = {s_q, s_q};
        // Slot k carries F[32-k]; slot 0 wraps to F[0] of the outgoing frame,
        // which is why s_q (not s_d) is the source here.
        bit_idx     = 5'd0 - new_bit;

        if (div_wrap) begin
            div_cnt_d = 8'd0;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end

        if (fall) begin
            bit_cnt_d = new_bit;
            lrclk_d   = new_bit[4];
            sdata_d   = frame[bit_idx];
        end

        if (frame_start && !pop) begin
            underrun_d = 1'b1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = sample_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            s_d      = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        ready_d = (count_d < DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= 8'd0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 5'd0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b1;
            s_q        <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 3'd0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            s_q        <= s_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign sample_ready = ready_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (CLK_DIV=4, FIFO_DEPTH=2): edge-numbered steps
// after reset release, with frame contents derived from F = {S, S}.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_in = 16'd0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] prev_s = 16'd0;

    i2s_tx #(.CLK_DIV(4), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    // Called on the edge where bit_cnt becomes 0.
    task automatic frame_start(input logic exp_under, input string tag);
        chk({tag, "_underrun"}, 32'(underrun), 32'(exp_under));
        chk({tag, "_sdata_k0"}, 32'(sdata), 32'(prev_s[0]));
        chk({tag, "_lrclk_k0"}, 32'(lrclk), 32'd0);
    endtask

    task automatic frame_body(input logic [15:0] s, input int start, input int kmax, input string tag);
        logic [31:0] f;
        f = {s, s};
        for (int k = 1; k <= kmax; k++) begin
            goto(start + 8 * k);
            chk($sformatf("%s_sdata_k%0d", tag, k), 32'(sdata), 32'(f[32 - k]));
            chk($sformatf("%s_lrclk_k%0d", tag, k), 32'(lrclk), (k >= 16) ? 32'd1 : 32'd0);
        end
        prev_s = s;
    endtask

    initial begin
        // Reset values
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_lrclk", 32'(lrclk), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd1);

        reset = 1'b0;
        cyc = 0;

        // Divider timing and first push
        goto(3);  chk("bclk_e3", 32'(bclk), 32'd0);
        goto(4);  chk("bclk_rise_e4", 32'(bclk), 32'd1);
        goto(8);  chk("bclk_fall_e8", 32'(bclk), 32'd0);
        chk("lrclk_e8", 32'(lrclk), 32'd0);
        goto(10);
        sample_in = 16'h8001;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("ready_after_one", 32'(sample_ready), 32'd1);
        goto(12);  chk("bclk_e12", 32'(bclk), 32'd1);
        goto(127); chk("lrclk_e127", 32'(lrclk), 32'd0);
        goto(128); chk("lrclk_rise_e128", 32'(lrclk), 32'd1);
        goto(255); chk("underrun_e255", 32'(underrun), 32'd0);

        // Frame 1: 0x8001 popped, no underrun
        goto(256);
        frame_start(1'b0, "f1");
        chk("f1_ready", 32'(sample_ready), 32'd1);
        frame_body(16'h8001, 256, 31, "f1");

        // Frame 2: FIFO empty, S repeated
        goto(512);
        frame_start(1'b1, "f2");
        goto(513);
        chk("f2_underrun_pulse_end", 32'(underrun), 32'd0);
        frame_body(16'h8001, 512, 31, "f2");

        // Fill FIFO with valid held high
        goto(761);
        sample_in = 16'h1234;
        sample_valid = 1'b1;
        tick();
        chk("fill_ready_1", 32'(sample_ready), 32'd1);
        sample_in = 16'h5678;
        tick();
        chk("fill_ready_full", 32'(sample_ready), 32'd0);
        sample_in = 16'h9abc;
        goto(767);
        chk("full_ready_held", 32'(sample_ready), 32'd0);

        // Frame 3: pop 0x1234, ready rises, then held valid pushes 0x9abc
        goto(768);
        frame_start(1'b0, "f3");
        chk("f3_ready_after_pop", 32'(sample_ready), 32'd1);
        tick();
        sample_valid = 1'b0;
        chk("f3_ready_refull", 32'(sample_ready), 32'd0);
        frame_body(16'h1234, 768, 31, "f3");

        goto(1024);
        frame_start(1'b0, "f4");
        frame_body(16'h5678, 1024, 31, "f4");

        goto(1280);
        frame_start(1'b0, "f5");
        frame_body(16'h9abc, 1280, 31, "f5");

        // Frame 6: push coincident with frame-start on empty FIFO
        goto(1535);
        sample_in = 16'hc3a5;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        frame_start(1'b1, "f6");
        chk("f6_ready", 32'(sample_ready), 32'd1);
        frame_body(16'h9abc, 1536, 31, "f6");

        // Frame 7: pushed sample appears; fill FIFO, then reset at bit_cnt 20
        goto(1792);
        frame_start(1'b0, "f7");
        sample_in = 16'h1111;
        sample_valid = 1'b1;
        tick();
        sample_in = 16'h2222;
        tick();
        sample_valid = 1'b0;
        chk("f7_ready_full", 32'(sample_ready), 32'd0);
        frame_body(16'hc3a5, 1792, 20, "f7");
        reset = 1'b1;
        tick();
        chk("mid_rst_bclk", 32'(bclk), 32'd0);
        chk("mid_rst_lrclk", 32'(lrclk), 32'd0);
        chk("mid_rst_sdata", 32'(sdata), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        chk("mid_rst_ready", 32'(sample_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        cyc = 0;
        prev_s = 16'd0;

        // Restart: timing as after power-on, FIFO and S flushed
        goto(3);   chk("rs_bclk_e3", 32'(bclk), 32'd0);
        goto(4);   chk("rs_bclk_rise_e4", 32'(bclk), 32'd1);
        goto(8);   chk("rs_bclk_fall_e8", 32'(bclk), 32'd0);
        chk("rs_sdata_e8", 32'(sdata), 32'd0);
        goto(127); chk("rs_lrclk_e127", 32'(lrclk), 32'd0);
        goto(128); chk("rs_lrclk_e128", 32'(lrclk), 32'd1);
        goto(255); chk("rs_underrun_e255", 32'(underrun), 32'd0);
        goto(256);
        frame_start(1'b1, "rs");
        goto(257);
        chk("rs_underrun_e257", 32'(underrun), 32'd0);
        frame_body(16'h0000, 256, 31, "rs");
        goto(512);
        frame_start(1'b1, "rs2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
